cpu_core_hs: RTL and testbench

Parametrised multi-cycle CPU core. It generalises the fixed 32-bit, fixed-latency stage-counter CPU to a configurable data width, register-file depth and memory address width. It replaces the in-core main memory with an external request/grant/response memory port that tolerates arbitrary wait states, and adds a hardwired-zero r0, HALT, illegal-opcode trapping and a retired-instruction counter. The block is the processor top and connects directly to a memory/arbiter block.

---
 rtl/cpu_core_hs.sv | 196 +++++++++++++++++++
 tb/tb_cpu_core_hs.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_hs.sv
// cpu_core_hs: parametrised multi-cycle core with a
// req/gnt/rvalid memory port, HALT, traps and retire count.
module cpu_core_hs #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);

  localparam logic [4:0] OP_LOADI = 5'd1;
  localparam logic [4:0] OP_LOAD  = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_ALU   = 5'd4;
  localparam logic [4:0] OP_JNZ   = 5'd5;
  localparam logic [4:0] OP_HALT  = 5'd6;

  typedef enum logic [3:0] {
    S_BOOT, S_FREQ, S_FWAIT, S_DEC, S_EXE,
    S_MREQ, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_rf [NREGS];
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_res;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic [31:0]       r_retired;
  logic              r_halted;
  logic              r_error;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;

  logic [4:0]        w_op;
  logic [RW-1:0]     w_rd;
  logic [RW-1:0]     w_rs0;
  logic [RW-1:0]     w_rs1;
  logic [2:0]        w_fn;
  logic [XLEN-1:0]   w_imm_x;
  logic [XLEN-1:0]   w_opa;
  logic [XLEN-1:0]   w_opb;
  logic [XLEN-1:0]   w_alu;
  logic [ADDR_W-1:0] w_pc1;
  logic              w_is_st;
  logic              w_wr_en;

  assign w_op    = r_ir[31:27];
  assign w_rd    = r_ir[22 +: RW];
  assign w_rs0   = r_ir[17 +: RW];
  assign w_rs1   = r_ir[12 +: RW];
  assign w_fn    = r_ir[2:0];
  assign w_imm_x = {{(XLEN-16){1'b0}}, r_ir[15:0]};
  // r0 reads as zero regardless of array contents
  assign w_opa   = (w_rs0 == '0) ? '0 : r_rf[w_rs0];
  assign w_opb   = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
  assign w_pc1   = r_pc + ADDR_W'(1);
  assign w_is_st = (w_op == OP_STORE);
  assign w_wr_en = (w_rd != '0) &&
                   ((w_op == OP_LOADI) ||
                    (w_op == OP_LOAD)  ||
                    (w_op == OP_ALU));

  always_comb begin
    w_alu = '0;
    unique case (w_fn)
      3'd0: w_alu = r_a + r_b;
      3'd1: w_alu = r_a - r_b;
      3'd2: w_alu = r_a & r_b;
      3'd3: w_alu = r_a | r_b;
      3'd4: w_alu = r_a ^ r_b;
      3'd5: w_alu = r_a << r_b[SW-1:0];
      3'd6: w_alu = r_a >> r_b[SW-1:0];
      3'd7: w_alu = {{(XLEN-1){1'b0}}, (r_a < r_b)};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_BOOT;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_pc        <= '0;
      r_npc       <= '0;
      r_retired   <= '0;
      r_halted    <= 1'b0;
      r_error     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
          r_state    <= S_FREQ;
        end
        S_FREQ: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_state   <= S_FWAIT;
        end
        S_FWAIT: if (mem_rvalid) begin
          r_ir    <= mem_rdata[31:0];
          r_state <= S_DEC;
        end
        S_DEC: begin
          r_a <= w_opa;
          r_b <= w_opb;
          unique case (1'b1)
            (w_op == OP_HALT): begin
              r_halted  <= 1'b1;
              r_retired <= r_retired + 32'd1;
              r_state   <= S_HALT;
            end
            (w_op > OP_HALT): begin
              r_halted <= 1'b1;
              r_error  <= 1'b1;
              r_state  <= S_HALT;
            end
            default: r_state <= S_EXE;
          endcase
        end
        S_EXE: begin
          r_npc <= (w_op == OP_JNZ && r_a != '0) ?
                   r_b[ADDR_W-1:0] : w_pc1;
          r_res <= (w_op == OP_LOADI) ? w_imm_x : w_alu;
          if (w_op == OP_LOAD || w_is_st) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_is_st;
            r_mem_addr <= w_is_st ? r_b[ADDR_W-1:0]
                                  : r_a[ADDR_W-1:0];
            if (w_is_st)
              r_mem_wdata <= r_a;
            r_state <= S_MREQ;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MREQ: if (mem_gnt) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= r_mem_we ? S_WB : S_MWAIT;
        end
        S_MWAIT: if (mem_rvalid) begin
          r_res   <= mem_rdata;
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_wr_en)
            r_rf[w_rd] <= r_res;
          r_pc       <= r_npc;
          r_retired  <= r_retired + 32'd1;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_npc;
          r_state    <= S_FREQ;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = r_halted;
  assign error     = r_error;
  assign pc        = r_pc;
  assign retired   = r_retired;
endmodule

// File: tb/tb_cpu_core_hs.sv
// tb_cpu_core_hs: random-latency memory responder plus an
// instruction-level reference interpreter for cpu_core_hs.
module tb_cpu_core_hs;
  localparam int XLEN = 32;
  localparam int AW   = 11;
  localparam int MSZ  = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          halted;
  logic          error;
  logic [AW-1:0] pc;
  logic [31:0]   retired;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem   [MSZ];
  logic [31:0] m_mem [MSZ];
  logic [31:0] m_reg [32];
  logic [AW-1:0] m_pc;
  logic [31:0] m_ret;
  bit m_halt, m_err;

  bit rand_dly = 0;
  bit stray = 0;
  int gnt_dly = 0;
  int rv_dly = 0;

  cpu_core_hs #(.XLEN(XLEN), .NREGS(32), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .halted(halted), .error(error),
    .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_loadi(int rd, int imm);
    return {5'd1, 5'(rd), 6'd0, 16'(imm)};
  endfunction
  function automatic logic [31:0] f_load(int rd, int a);
    return {5'd2, 5'(rd), 5'(a), 17'd0};
  endfunction
  function automatic logic [31:0] f_store(int d, int a);
    return {5'd3, 5'd0, 5'(d), 5'(a), 12'd0};
  endfunction
  function automatic logic [31:0] f_alu(int fn, int rd, int a, int b);
    return {5'd4, 5'(rd), 5'(a), 5'(b), 9'd0, 3'(fn)};
  endfunction
  function automatic logic [31:0] f_jnz(int a, int b);
    return {5'd5, 5'd0, 5'(a), 5'(b), 12'd0};
  endfunction
  localparam logic [31:0] HALT = {5'd6, 27'd0};

  // Memory: grants after gnt_dly stalls, returns read data rv_dly
  // cycles after the grant; signals change on the falling edge.
  initial begin : responder
    int gw, rw;
    bit hold, hwe;
    logic [AW-1:0] ha;
    logic [31:0] hd;
    gw = 0; rw = -1; hold = 0; hwe = 0; ha = '0; hd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_gnt = 0; mem_rvalid = 0; rw = -1; hold = 0;
      end else begin
        mem_rvalid = 0;
        if (stray) begin
          mem_rvalid = 1;
          mem_rdata = 32'hF800_0000;
          stray = 0;
        end else begin
          if (mem_gnt) begin
            mem_gnt = 0;
            hold = 0;
            if (hwe) mem[ha] = hd;
            else rw = rand_dly ? int'($urandom_range(0, 3)) : rv_dly;
          end
          if (rw >= 0) begin
            if (rw == 0) begin
              mem_rvalid = 1;
              mem_rdata = mem[ha];
              rw = -1;
            end else rw--;
          end else if (mem_req) begin
            if (!hold) begin
              hold = 1; ha = mem_addr; hwe = mem_we; hd = mem_wdata;
              gw = rand_dly ? int'($urandom_range(0, 3)) : gnt_dly;
            end else begin
              vecs++;
              if (mem_addr !== ha || mem_we !== hwe ||
                  (hwe && mem_wdata !== hd)) begin
                errs++;
                $display("FAIL req_stable: addr %0d we %0b, want addr %0d we %0b",
                         mem_addr, mem_we, ha, hwe);
              end
            end
            if (gw == 0) mem_gnt = 1;
            else gw--;
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < MSZ; i++) mem[i] = '0;
  endtask

  task automatic snap();
    for (int i = 0; i < MSZ; i++) m_mem[i] = mem[i];
  endtask

  // Architectural interpreter: one loop iteration per instruction.
  task automatic model_run();
    logic [31:0] ins, a, b, r;
    logic [4:0] op, rd;
    int steps;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0; m_ret = '0; m_halt = 0; m_err = 0; steps = 0;
    while (!m_halt && steps < 400) begin
      steps++;
      ins = m_mem[m_pc];
      op = ins[31:27]; rd = ins[26:22];
      a = m_reg[ins[21:17]]; b = m_reg[ins[16:12]];
      r = '0;
      if (op == 5'd6) begin
        m_halt = 1; m_ret++;
      end else if (op > 5'd6) begin
        m_halt = 1; m_err = 1;
      end else begin
        case (op)
          5'd1: r = {16'd0, ins[15:0]};
          5'd2: r = m_mem[a[10:0]];
          5'd3: m_mem[b[10:0]] = a;
          5'd4: case (ins[2:0])
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = (a < b) ? 32'd1 : 32'd0;
          endcase
          default: ;
        endcase
        if ((op == 5'd1 || op == 5'd2 || op == 5'd4) && rd != 5'd0)
          m_reg[rd] = r;
        m_pc = (op == 5'd5 && a != 0) ? b[10:0] : m_pc + 11'd1;
        m_ret++;
      end
    end
  endtask

  task automatic run_prog(input int budget, output int cyc, output bit done);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    cyc = 1; done = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (halted) done = 1;
    end
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = HALT;
    rst = 0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({mem_req, mem_we, halted, error} !== 4'b0 || pc !== '0 ||
        retired !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errs++;
      $display("FAIL reset_vals: req %0b we %0b h %0b e %0b pc %0d ret %0d, want all 0",
               mem_req, mem_we, halted, error, pc, retired);
    end
    rst = 1;
    #1;
    vecs++;
    if (mem_req !== 1'b0) begin
      errs++; $display("FAIL boot_req: got %0b want 0", mem_req);
    end
    @(posedge clk); #1;
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== '0) begin
      errs++;
      $display("FAIL first_req: req %0b addr %0d, want 1 / 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_basic(input int gd, input int rd, input int exp_cyc);
    int cyc; bit done;
    clear_mem();
    mem[0] = f_loadi(1, 5);
    mem[1] = f_loadi(2, 7);
    mem[2] = f_alu(0, 3, 1, 2);
    mem[3] = f_store(3, 1);
    mem[4] = HALT;
    mem[5] = 32'hFFFF_FFFF;
    rand_dly = 0; gnt_dly = gd; rv_dly = rd;
    run_prog(300, cyc, done);
    vecs++;
    if (!done || cyc != exp_cyc) begin
      errs++;
      $display("FAIL basic_cycles(g%0d,r%0d): got %0d halted %0b want %0d",
               gd, rd, cyc, done, exp_cyc);
    end
    vecs++;
    if (mem[5] !== 32'd12 || retired !== 32'd5 || pc !== 11'd4 ||
        halted !== 1'b1 || error !== 1'b0) begin
      errs++;
      $display("FAIL basic_arch: mem5 %0d ret %0d pc %0d e %0b, want 12 5 4 0",
               mem[5], retired, pc, error);
    end
  endtask

  task automatic test_jnz();
    int cyc; bit done;
    clear_mem();
    mem[0] = f_loadi(1, 3);
    mem[1] = f_loadi(2, 1);
    mem[2] = f_loadi(4, 4);
    mem[3] = f_loadi(6, 100);
    mem[4] = f_alu(1, 1, 1, 2);
    mem[5] = f_alu(0, 5, 5, 2);
    mem[6] = f_jnz(1, 4);
    mem[7] = f_store(5, 6);
    mem[8] = HALT;
    rand_dly = 1;
    run_prog(800, cyc, done);
    vecs++;
    if (!done || mem[100] !== 32'd3 || retired !== 32'd15 || pc !== 11'd8) begin
      errs++;
      $display("FAIL jnz_loop: iters %0d ret %0d pc %0d, want 3 15 8",
               mem[100], retired, pc);
    end
  endtask

  task automatic test_wrap();
    bit saw;
    logic [AW-1:0] prev, wpc;
    clear_mem();
    mem[0] = f_jnz(3, 4);
    mem[1] = f_loadi(3, 1);
    mem[2] = f_loadi(4, 10);
    mem[3] = f_loadi(2, 2047);
    mem[4] = f_jnz(3, 2);
    mem[10] = HALT;
    rand_dly = 0; gnt_dly = 0; rv_dly = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    saw = 0; prev = '0; wpc = '1;
    for (int c = 0; c < 400 && !halted; c++) begin
      @(posedge clk); #1;
      if (!saw && prev == 11'd2047 && pc != 11'd2047) begin
        saw = 1; wpc = pc;
      end
      prev = pc;
    end
    vecs++;
    if (!saw || wpc !== '0) begin
      errs++;
      $display("FAIL pc_wrap: seen %0b next pc %0d, want 1 / 0", saw, wpc);
    end
    vecs++;
    if (halted !== 1'b1 || pc !== 11'd10 || retired !== 32'd8) begin
      errs++;
      $display("FAIL wrap_end: h %0b pc %0d ret %0d, want 1 10 8",
               halted, pc, retired);
    end
  endtask

  task automatic test_illegal();
    int cyc, nreq; bit done;
    clear_mem();
    mem[0] = f_loadi(1, 7);
    mem[1] = 32'hF800_0000;
    rand_dly = 0; gnt_dly = 1; rv_dly = 1;
    run_prog(200, cyc, done);
    vecs++;
    if (!done || error !== 1'b1 || retired !== 32'd1 || pc !== 11'd1) begin
      errs++;
      $display("FAIL illegal: h %0b e %0b ret %0d pc %0d, want 1 1 1 1",
               halted, error, retired, pc);
    end
    nreq = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mem_req) nreq++;
    end
    vecs++;
    if (nreq != 0) begin
      errs++; $display("FAIL illegal_quiet: req cycles %0d want 0", nreq);
    end
  endtask

  task automatic test_r0();
    int cyc; bit done;
    clear_mem();
    mem[0] = f_loadi(0, 9);
    mem[1] = f_loadi(1, 50);
    mem[2] = f_store(0, 1);
    mem[3] = HALT;
    mem[50] = 32'hDEAD_BEEF;
    rand_dly = 1;
    run_prog(300, cyc, done);
    vecs++;
    if (!done || mem[50] !== 32'd0 || retired !== 32'd4) begin
      errs++;
      $display("FAIL r0_zero: stored %0h ret %0d, want 0 4", mem[50], retired);
    end
  endtask

  task automatic test_reset_mid();
    bit found, done;
    logic [31:0] val;
    clear_mem();
    val = $urandom;
    mem[0] = f_loadi(1, 300);
    mem[1] = f_loadi(3, 301);
    mem[2] = f_load(2, 1);
    mem[3] = f_store(2, 3);
    mem[4] = HALT;
    mem[300] = val;
    rand_dly = 0; gnt_dly = 0; rv_dly = 8;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_we && mem_addr == 11'd300) found = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    vecs++;
    if (!found || pc !== '0 || retired !== '0 || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: load seen %0b pc %0d ret %0d req %0b, want 1 0 0 0",
               found, pc, retired, mem_req);
    end
    @(negedge clk);
    rv_dly = 0;
    rst = 1;
    stray = 1;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      if (halted) done = 1;
    end
    vecs++;
    if (!done || error !== 1'b0 || mem[301] !== val ||
        retired !== 32'd5 || pc !== 11'd4) begin
      errs++;
      $display("FAIL restart: h %0b e %0b m301 %0h ret %0d pc %0d, want 1 0 %0h 5 4",
               done, error, mem[301], val, retired, pc);
    end
  endtask

  task automatic test_random();
    int cyc, len, p, k, nbad;
    bit done;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < MSZ; i++) mem[i] = $urandom;
      len = $urandom_range(10, 20);
      for (int i = 0; i < len; i++) begin
        k = $urandom_range(0, 9);
        case (k)
          0: mem[i] = '0;
          1, 2, 3: mem[i] = f_loadi($urandom_range(0, 7), $urandom);
          4, 5, 6: mem[i] = f_alu($urandom_range(0, 7), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 7));
          7: mem[i] = f_load($urandom_range(0, 7), $urandom_range(0, 7));
          default: mem[i] = f_store($urandom_range(0, 7), $urandom_range(0, 7));
        endcase
      end
      p = len;
      for (int r = 1; r < 8; r++) begin
        mem[p] = f_loadi(31, 1000 + r); p++;
        mem[p] = f_store(r, 31); p++;
      end
      mem[p] = ($urandom_range(0, 3) == 0) ?
               {5'($urandom_range(7, 31)), 27'd0} : HALT;
      snap();
      model_run();
      if (m_halt) begin
        rand_dly = 1;
        run_prog(8000, cyc, done);
        vecs++;
        if (!done || error !== m_err || pc !== m_pc || retired !== m_ret) begin
          errs++;
          $display("FAIL rand%0d_state: h %0b e %0b pc %0d ret %0d, want 1 %0b %0d %0d",
                   t, done, error, pc, retired, m_err, m_pc, m_ret);
        end
        nbad = 0;
        for (int i = 0; i < MSZ; i++)
          if (mem[i] !== m_mem[i]) nbad++;
        vecs++;
        if (nbad != 0) begin
          errs++;
          $display("FAIL rand%0d_mem: %0d words differ, want 0", t, nbad);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(0, 0, 26);
    test_basic(3, 2, 54);
    test_jnz();
    test_wrap();
    test_illegal();
    test_r0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
